// File: rtl/mitchell_log_front.sv
// Mitchell log front end: leading-one index K and MSB-aligned fraction M of one unsigned operand.
// Latency: 2 cycles from input transfer to OUT_VALID; one result per cycle when unstalled.
// Backpressure: OUT_READY stalls S2, then S1; IN_READY drops only when both stages are held.
// Optional macro MLOG_TRUNC_EN: zeroes the wl_trunc LSBs of M at the S2 register.
module mitchell_log_front #(
  parameter int wl_x     = 32,
  parameter int wl_m     = wl_x - 1,
  parameter int wl_k     = 5,
  parameter int wl_trunc = 8
) (
  input  logic            CLK,
  input  logic            RST_N,
  input  logic            IN_VALID,
  output logic            IN_READY,
  input  logic [wl_x-1:0] X,
  output logic            OUT_VALID,
  input  logic            OUT_READY,
  output logic [wl_k-1:0] K,
  output logic [wl_m-1:0] M,
  output logic            ZERO
);

  localparam logic [wl_k-1:0] MAX_K = wl_k'(wl_x - 1);

  // Stage 1 state: only the bits below the MSB are kept, since the leading
  // one itself is shifted out of M and never needed again.
  logic            s1_vld;
  logic [wl_m-1:0] s1_x;
  logic [wl_k-1:0] s1_k;
  logic            s1_z;

  // Stage 2 state drives the outputs directly.
  logic            s2_vld;
  logic [wl_k-1:0] s2_k;
  logic [wl_m-1:0] s2_m;
  logic            s2_z;

  logic            s1_load;
  logic            s2_load;

  logic [wl_k-1:0] k1_d;
  logic            z1_d;
  logic [wl_k-1:0] shamt;
  logic [wl_m-1:0] m_d;
  logic [wl_k-1:0] k_d;

  // Advance control: S2 moves when empty or drained, S1 moves when empty or S2 moves.
  always_comb begin
    s2_load  = !s2_vld || OUT_READY;
    s1_load  = !s1_vld || s2_load;
    IN_READY = s1_load;
  end

  // Priority encoder: highest set bit of X wins (later loop iterations override).
  always_comb begin
    k1_d = '0;
    for (int i = 0; i < wl_x; i++) begin
      if (X[i]) k1_d = i[wl_k-1:0];
    end
    z1_d = (X == '0);
  end

  // Stage 1 register: capture operand, index and zero flag on input transfer.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_vld <= 1'b0;
      s1_x   <= '0;
      s1_k   <= '0;
      s1_z   <= 1'b0;
    end else if (s1_load) begin
      s1_vld <= IN_VALID;
      if (IN_VALID) begin
        s1_x <= X[wl_m-1:0];
        s1_k <= k1_d;
        s1_z <= z1_d;
      end
    end
  end

  // Normalising shift: moving the leading one to bit wl_m drops it out of the
  // wl_m-bit result, leaving exactly the fraction bits MSB-aligned.
  always_comb begin
    shamt = MAX_K - s1_k;
    m_d   = s1_x << shamt;
    k_d   = s1_k;
    if (s1_z) begin
      m_d = '0;
      k_d = '0;
    end
`ifdef MLOG_TRUNC_EN
    m_d[wl_trunc-1:0] = '0;
`else
`endif
  end

  // Stage 2 register: data updates only when a valid S1 entry moves in, so
  // a held result stays stable under backpressure.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s2_vld <= 1'b0;
      s2_k   <= '0;
      s2_m   <= '0;
      s2_z   <= 1'b0;
    end else if (s2_load) begin
      s2_vld <= s1_vld;
      if (s1_vld) begin
        s2_k <= k_d;
        s2_m <= m_d;
        s2_z <= s1_z;
      end
    end
  end

  // Output mapping.
  always_comb begin
    OUT_VALID = s2_vld;
    K         = s2_k;
    M         = s2_m;
    ZERO      = s2_z;
  end

endmodule
